memory_interface_ws: RTL and testbench

//  Parametrised successor to the simulation memory model. Word-organised RAM behind a

---
 rtl/memory_interface_ws.sv | 231 +++++++++++++++++++++++
 tb/tb_memory_interface_ws.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_interface_ws.sv
// memory_interface_ws: word-organised RAM behind a valid/ready request/response
// handshake, with programmable wait states and a relocatable base address.
// One request is in flight at a time.
// Optional feature macro: MEM_IF_SIGN_EXT_EN (adds i_req_signed; signed BYTE/HALF reads).
// Count encoding: NONE=0 BYTE=1 HALF=2 WORD=3.
// Code encoding:  READ=0 WRITE=1 MISALIGNED=2 OUT_OF_BOUNDS=3 INVALID=4.
module memory_interface_ws #(
  parameter int          WORD_COUNT  = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wr_data,
  input  logic        i_req_wr_en,
  input  logic [1:0]  i_req_count,
`ifdef MEM_IF_SIGN_EXT_EN
  input  logic        i_req_signed,
`endif
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_rd_data,
  output logic [2:0]  o_res_code
);

  localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] CNT_BYTE = 2'd1;
  localparam logic [1:0] CNT_HALF = 2'd2;
  localparam logic [1:0] CNT_WORD = 2'd3;

  localparam logic [2:0] CODE_READ  = 3'd0;
  localparam logic [2:0] CODE_WRITE = 3'd1;
  localparam logic [2:0] CODE_MIS   = 3'd2;
  localparam logic [2:0] CODE_OOB   = 3'd3;
  localparam logic [2:0] CODE_INV   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        wr_en_r;
  logic [1:0]  count_r;
`ifdef MEM_IF_SIGN_EXT_EN
  logic        signed_r;
`endif
  logic [31:0] mem_r [WORD_COUNT];

  logic        req_ready_r;
  logic        res_valid_r;
  logic [31:0] rd_data_r;
  logic [2:0]  code_r;

  logic        accept_s;
  logic        access_s;
  logic [31:0] word_off_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0] cur_word_s;
  logic [31:0] lane_word_s;
  logic [31:0] new_word_s;
  logic [31:0] rd_s;
  logic [2:0]  code_s;
  logic        commit_s;
  logic        mis_s;
  logic        oob_s;

  // Accept only when the registered ready is up, so ready stays low for one edge after reset
  assign accept_s = (state_r == ST_IDLE) && req_ready_r && i_req_valid;
  // The access happens once the wait counter has drained; WAIT always lasts at least one
  // edge so that the response appears WAIT_CYCLES+1 edges after the accept edge.
  assign access_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_WAIT;
        else          state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) state_next_s = ST_RESP;
        else               state_next_s = ST_WAIT;
      end
      ST_RESP: begin
        if (i_res_ready) state_next_s = ST_IDLE;
        else             state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Capture the request on accept; hold it otherwise
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr_r   <= 32'h0;
      wdata_r  <= 32'h0;
      wr_en_r  <= 1'b0;
      count_r  <= 2'd0;
`ifdef MEM_IF_SIGN_EXT_EN
      signed_r <= 1'b0;
`endif
    end else if (accept_s) begin
      addr_r   <= i_req_addr;
      wdata_r  <= i_req_wr_data;
      wr_en_r  <= i_req_wr_en;
      count_r  <= i_req_count;
`ifdef MEM_IF_SIGN_EXT_EN
      signed_r <= i_req_signed;
`endif
    end
  end

  // Wait-state counter: loaded on accept, drained one per edge in WAIT
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= 4'd0;
    end else if (accept_s) begin
      cnt_r <= WAIT_INIT;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Access checks in priority order, write-lane merge and read-lane extraction
  always_comb begin
    word_off_s  = (addr_r - BASE_ADDR) >> 2;
    idx_s       = word_off_s[IDX_W-1:0];
    cur_word_s  = mem_r[idx_s];
    lane_word_s = cur_word_s >> {addr_r[1:0], 3'b000};
    new_word_s  = cur_word_s;
    rd_s        = 32'h0;
    code_s      = CODE_INV;
    commit_s    = 1'b0;
    oob_s       = (addr_r < BASE_ADDR) || (word_off_s >= 32'(WORD_COUNT));
    case (count_r)
      CNT_HALF: mis_s = addr_r[0];
      CNT_WORD: mis_s = |addr_r[1:0];
      default:  mis_s = 1'b0;
    endcase
    if (count_r == 2'd0) begin
      code_s = CODE_INV;
    end else if (mis_s) begin
      code_s = CODE_MIS;
    end else if (oob_s) begin
      code_s = CODE_OOB;
    end else if (wr_en_r) begin
      code_s   = CODE_WRITE;
      commit_s = access_s;
      case (count_r)
        CNT_BYTE: new_word_s[{addr_r[1:0], 3'b000} +: 8]  = wdata_r[7:0];
        CNT_HALF: new_word_s[{addr_r[1], 4'b0000} +: 16]  = wdata_r[15:0];
        CNT_WORD: new_word_s = wdata_r;
        default:  new_word_s = cur_word_s;
      endcase
    end else begin
      code_s = CODE_READ;
      case (count_r)
`ifdef MEM_IF_SIGN_EXT_EN
        CNT_BYTE: begin
          if (signed_r) rd_s = {{24{lane_word_s[7]}}, lane_word_s[7:0]};
          else          rd_s = {24'h0, lane_word_s[7:0]};
        end
        CNT_HALF: begin
          if (signed_r) rd_s = {{16{lane_word_s[15]}}, lane_word_s[15:0]};
          else          rd_s = {16'h0, lane_word_s[15:0]};
        end
`else
        CNT_BYTE: rd_s = {24'h0, lane_word_s[7:0]};
        CNT_HALF: rd_s = {16'h0, lane_word_s[15:0]};
`endif
        CNT_WORD: rd_s = lane_word_s;
        default:  rd_s = 32'h0;
      endcase
    end
  end

  // Memory array: cleared by reset, written only on a committed WRITE
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (commit_s) begin
      mem_r[idx_s] <= new_word_s;
    end
  end

  // Registered handshake outputs and response payload
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      rd_data_r   <= 32'h0;
      code_r      <= CODE_INV;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      res_valid_r <= (state_next_s == ST_RESP);
      if (access_s) begin
        rd_data_r <= rd_s;
        code_r    <= code_s;
      end
    end
  end

  assign o_req_ready   = req_ready_r;
  assign o_res_valid   = res_valid_r;
  assign o_res_rd_data = rd_data_r;
  assign o_res_code    = code_r;

endmodule

// File: tb/tb_memory_interface_ws.sv
// Testbench for memory_interface_ws: directed scenarios plus randomized requests checked
// against a byte-level reference model of the memory.
module tb_memory_interface_ws;

  localparam int          WC    = 16;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  localparam logic [2:0] C_READ  = 3'd0;
  localparam logic [2:0] C_WRITE = 3'd1;
  localparam logic [2:0] C_MIS   = 3'd2;
  localparam logic [2:0] C_OOB   = 3'd3;
  localparam logic [2:0] C_INV   = 3'd4;

`ifdef MEM_IF_SIGN_EXT_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wr_data;
  logic        i_req_wr_en;
  logic [1:0]  i_req_count;
  logic        i_req_signed;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [31:0] o_res_rd_data;
  logic [2:0]  o_res_code;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [WC];

  always #5 clk = ~clk;

  memory_interface_ws #(
    .WORD_COUNT (WC),
    .WAIT_CYCLES(WAITC),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_wr_data(i_req_wr_data),
    .i_req_wr_en  (i_req_wr_en),
    .i_req_count  (i_req_count),
`ifdef MEM_IF_SIGN_EXT_EN
    .i_req_signed (i_req_signed),
`endif
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_rd_data(o_res_rd_data),
    .o_res_code   (o_res_code)
  );

  // Reference model: byte-lane view of memory, computed with plain arithmetic
  task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic wr, input logic [1:0] cnt, input logic sgn,
                              output logic [2:0] code, output logic [31:0] data);
    int size;
    int lane;
    int idx;
    longint off;
    logic [31:0] w;
    logic [31:0] mask;
    data = 32'h0;
    if (cnt == 2'd0) begin
      code = C_INV;
      return;
    end
    size = 1 << (int'(cnt) - 1);
    if ((addr % size) != 0) begin
      code = C_MIS;
      return;
    end
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || (off / 4) >= WC) begin
      code = C_OOB;
      return;
    end
    idx  = int'(off / 4);
    lane = int'(addr % 4);
    w    = model_mem[idx];
    mask = 32'((64'd1 << (8 * size)) - 64'd1);
    if (wr) begin
      for (int b = 0; b < size; b++) w[8*(lane+b) +: 8] = wdata[8*b +: 8];
      model_mem[idx] = w;
      code = C_WRITE;
    end else begin
      data = (w >> (8 * lane)) & mask;
      if (SIGN_EN && sgn && size < 4 && data[8*size-1]) data = data | ~mask;
      code = C_READ;
    end
  endtask

  // Issue one request, observe response, optionally stall the consumer for 'hold' cycles
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input logic [1:0] cnt, input logic sgn, input int hold,
                         output logic [2:0] code, output logic [31:0] data, output int lat,
                         output bit stable);
    int guard;
    guard  = 0;
    stable = 1'b1;
    while (!o_req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    i_req_valid   = 1'b1;
    i_req_addr    = addr;
    i_req_wr_data = wdata;
    i_req_wr_en   = wr;
    i_req_count   = cnt;
    i_req_signed  = sgn;
    @(posedge clk); #1;
    // Scramble request inputs: they must be ignored outside IDLE
    i_req_valid   = 1'($urandom_range(0, 1));
    i_req_addr    = $urandom;
    i_req_wr_data = $urandom;
    i_req_wr_en   = 1'($urandom_range(0, 1));
    i_req_count   = 2'($urandom_range(0, 3));
    lat = 0;
    while (!o_res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    code = o_res_code;
    data = o_res_rd_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!o_res_valid || o_res_code !== code || o_res_rd_data !== data || o_req_ready)
        stable = 1'b0;
    end
    i_req_valid = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    aresetn = 1'b0;
    #12;
    checks++;
    if (o_res_valid !== 1'b0 || o_res_code !== C_INV || o_res_rd_data !== 32'h0 ||
        o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b code=%0d data=%h ready=%b expected 0,%0d,0,0",
               o_res_valid, o_res_code, o_res_rd_data, o_req_ready, C_INV);
    end
    for (int i = 0; i < WC; i++) model_mem[i] = 32'h0;
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", o_req_ready);
    end
    for (int i = 0; i < WC; i++) begin
      run_req(BASE + 32'(4 * i), 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
      checks++;
      if (code !== C_READ || data !== 32'h0) begin
        errors++;
        $display("FAIL reset_word%0d: got code=%0d data=%h expected %0d,00000000", i, code, data, C_READ);
      end
    end
  endtask

  task automatic test_write_read();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    logic [2:0] ec; logic [31:0] ed;
    run_req(BASE + 32'h10, 32'hDEADBEEF, 1'b1, 2'd3, 1'b0, 0, code, data, lat, st);
    model_access(BASE + 32'h10, 32'hDEADBEEF, 1'b1, 2'd3, 1'b0, ec, ed);
    checks++;
    if (code !== C_WRITE || data !== 32'h0 || lat != WAITC + 1) begin
      errors++;
      $display("FAIL word_write: got code=%0d data=%h lat=%0d expected %0d,0,%0d", code, data, lat, C_WRITE, WAITC + 1);
    end
    run_req(BASE + 32'h13, 32'h0, 1'b0, 2'd1, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_READ || data !== 32'h000000DE || lat != WAITC + 1) begin
      errors++;
      $display("FAIL byte_read: got code=%0d data=%h lat=%0d expected %0d,000000de,%0d", code, data, lat, C_READ, WAITC + 1);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    run_req(BASE + 32'h11, 32'h0000FFFF, 1'b1, 2'd2, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_MIS || data !== 32'h0) begin
      errors++;
      $display("FAIL half_misaligned: got code=%0d data=%h expected %0d,0", code, data, C_MIS);
    end
    run_req(BASE + 32'h10, 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_READ || data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL after_misaligned: got code=%0d data=%h expected %0d,deadbeef", code, data, C_READ);
    end
  endtask

  task automatic test_bounds();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    run_req(BASE + 32'(4 * WC), 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_OOB || data !== 32'h0) begin
      errors++;
      $display("FAIL oob_high: got code=%0d data=%h expected %0d,0", code, data, C_OOB);
    end
    run_req(BASE - 32'd4, 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_OOB || data !== 32'h0) begin
      errors++;
      $display("FAIL oob_low: got code=%0d data=%h expected %0d,0", code, data, C_OOB);
    end
    run_req(BASE - 32'd4, 32'h1234, 1'b1, 2'd0, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_INV || data !== 32'h0) begin
      errors++;
      $display("FAIL invalid_count: got code=%0d data=%h expected %0d,0", code, data, C_INV);
    end
  endtask

  task automatic test_hold();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    run_req(BASE + 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 5, code, data, lat, st);
    checks++;
    if (st !== 1'b1 || code !== C_READ || data !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL hold_stable: got stable=%b code=%0d data=%h expected 1,%0d,0000beef", st, code, data, C_READ);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] code; logic [31:0] data; int lat; bit st; int guard;
    guard = 0;
    while (!o_req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    i_req_valid = 1'b1; i_req_addr = BASE + 32'h20; i_req_wr_data = 32'h12345678;
    i_req_wr_en = 1'b1; i_req_count = 2'd3;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b0;
    #2;
    checks++;
    if (o_res_valid !== 1'b0 || o_req_ready !== 1'b0 || o_res_code !== C_INV) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b ready=%b code=%0d expected 0,0,%0d", o_res_valid, o_req_ready, o_res_code, C_INV);
    end
    for (int i = 0; i < WC; i++) model_mem[i] = 32'h0;
    @(negedge clk) aresetn = 1'b1;
    run_req(BASE + 32'h20, 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_READ || data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_word: got code=%0d data=%h expected %0d,00000000", code, data, C_READ);
    end
  endtask

  task automatic test_sign_ext();
`ifdef MEM_IF_SIGN_EXT_EN
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    logic [2:0] ec; logic [31:0] ed;
    run_req(BASE, 32'h00008080, 1'b1, 2'd3, 1'b0, 0, code, data, lat, st);
    model_access(BASE, 32'h00008080, 1'b1, 2'd3, 1'b0, ec, ed);
    run_req(BASE, 32'h0, 1'b0, 2'd1, 1'b1, 0, code, data, lat, st);
    checks++;
    if (code !== C_READ || data !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL signed_byte: got code=%0d data=%h expected %0d,ffffff80", code, data, C_READ);
    end
    run_req(BASE, 32'h0, 1'b0, 2'd1, 1'b0, 0, code, data, lat, st);
    checks++;
    if (code !== C_READ || data !== 32'h00000080) begin
      errors++;
      $display("FAIL unsigned_byte: got code=%0d data=%h expected %0d,00000080", code, data, C_READ);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0] code; logic [31:0] data; int lat; bit st;
    logic [2:0] ec; logic [31:0] ed;
    logic [31:0] a; logic [31:0] wd; logic wr; logic [1:0] cnt; logic sg;
    for (int n = 0; n < 80; n++) begin
      a   = BASE - 32'd8 + 32'($urandom_range(0, 4 * WC + 16));
      wd  = $urandom;
      wr  = 1'($urandom_range(0, 1));
      cnt = 2'($urandom_range(0, 3));
      sg  = 1'($urandom_range(0, 1));
      run_req(a, wd, wr, cnt, sg, 0, code, data, lat, st);
      model_access(a, wd, wr, cnt, sg, ec, ed);
      checks++;
      if (code !== ec || data !== ed || lat != WAITC + 1) begin
        errors++;
        $display("FAIL random%0d: addr=%h got code=%0d data=%h lat=%0d expected %0d,%h,%0d",
                 n, a, code, data, lat, ec, ed, WAITC + 1);
      end
    end
    for (int i = 0; i < WC; i++) begin
      run_req(BASE + 32'(4 * i), 32'h0, 1'b0, 2'd3, 1'b0, 0, code, data, lat, st);
      checks++;
      if (code !== C_READ || data !== model_mem[i]) begin
        errors++;
        $display("FAIL final_word%0d: got code=%0d data=%h expected %0d,%h", i, code, data, C_READ, model_mem[i]);
      end
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    i_req_valid   = 1'b0;
    i_req_addr    = 32'h0;
    i_req_wr_data = 32'h0;
    i_req_wr_en   = 1'b0;
    i_req_count   = 2'd0;
    i_req_signed  = 1'b0;
    i_res_ready   = 1'b0;
    test_reset();
    test_write_read();
    test_misaligned();
    test_bounds();
    test_hold();
    test_reset_mid();
    test_sign_ext();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
